// File: rtl/mult_pkg.sv
// Shared definitions for the shared shift-add multiplier and its two-port arbiter.
package mult_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult_core.sv
// Shift-add datapath: one conditional add plus right shift per step.
module mult_core
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_acc_c
);

    logic [WIDTH:0]   r_upper;
    logic [WIDTH-1:0] r_lower;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_upper_nxt;
    logic [WIDTH-1:0] w_lower_nxt;

    // {carry,upper} = upper + addend, then shift the whole accumulator right by one
    always_comb begin
        w_sum       = r_upper + (r_lower[0] ? {1'b0, r_mcand} : (WIDTH+1)'(0));
        w_upper_nxt = {1'b0, w_sum[WIDTH:1]};
        w_lower_nxt = {w_sum[0], r_lower[WIDTH-1:1]};
        o_acc_c     = i_step ? {w_upper_nxt[WIDTH-1:0], w_lower_nxt}
                             : {r_upper[WIDTH-1:0], r_lower};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_upper <= '0;
            r_lower <= '0;
            r_mcand <= '0;
        end else if (i_load) begin
            r_upper <= '0;
            r_lower <= i_b;
            r_mcand <= i_a;
        end else if (i_step) begin
            r_upper <= w_upper_nxt;
            r_lower <= w_lower_nxt;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin two-port front end and sequencer for the shared shift-add multiplier.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req0_valid,
    input  logic [WIDTH-1:0]     i_req0_a,
    input  logic [WIDTH-1:0]     i_req0_b,
    output logic                 o_req0_ready_c,
    input  logic                 i_req1_valid,
    input  logic [WIDTH-1:0]     i_req1_a,
    input  logic [WIDTH-1:0]     i_req1_b,
    output logic                 o_req1_ready_c,
    output logic                 o_resp0_valid,
    output logic                 o_resp1_valid,
    output logic [2*WIDTH-1:0]   o_resp_product,
    output logic                 o_busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_owner;
    logic               r_last_grant;
    logic               w_grant;
    logic               w_xfer;
    logic               w_step;
    logic               w_to_done;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [2*WIDTH-1:0] w_acc;

    mult_core #(.WIDTH(WIDTH)) u_core (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_xfer),
        .i_step  (w_step),
        .i_a     (w_a),
        .i_b     (w_b),
        .o_acc_c (w_acc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, grant selection and combinational readies
    always_comb begin
        w_next_state   = r_state;
        w_grant        = 1'b0;
        w_xfer         = 1'b0;
        w_step         = 1'b0;
        w_to_done      = 1'b0;
        o_req0_ready_c = 1'b0;
        o_req1_ready_c = 1'b0;
        w_a            = i_req0_a;
        w_b            = i_req0_b;
        case (r_state)
            IDLE: begin
                if (i_req0_valid && i_req1_valid) begin
                    w_grant = ~r_last_grant;
                end else begin
                    w_grant = i_req1_valid;
                end
                o_req0_ready_c = i_req0_valid && !w_grant;
                o_req1_ready_c = i_req1_valid && w_grant;
                w_xfer         = o_req0_ready_c || o_req1_ready_c;
                if (w_grant) begin
                    w_a = i_req1_a;
                    w_b = i_req1_b;
                end
                if (w_xfer) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_count == CNT_W'(WIDTH - 1)) begin
                    w_to_done    = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Step counter, ownership and round-robin history
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count      <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_count      <= '0;
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
        end else if (w_step) begin
            r_count      <= r_count + CNT_W'(1);
        end
    end

    // Product and strobe are captured on the edge entering DONE so they are valid during DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_resp0_valid  <= 1'b0;
            o_resp1_valid  <= 1'b0;
            o_resp_product <= '0;
            o_busy         <= 1'b0;
        end else begin
            o_resp0_valid <= w_to_done && !r_owner;
            o_resp1_valid <= w_to_done && r_owner;
            o_busy        <= (w_next_state != IDLE);
            if (w_to_done) begin
                o_resp_product <= w_acc;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: drivers push expected products, a monitor pops on each strobe.
module tb_mult_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp1_valid;
    logic [15:0] resp_product;
    logic        busy;

    typedef struct {
        int          port;
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   hs_port[$];
    int   hs_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    mult_arbiter #(.WIDTH(8)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req0_valid   (req0_valid),
        .i_req0_a       (req0_a),
        .i_req0_b       (req0_b),
        .o_req0_ready_c (req0_ready),
        .i_req1_valid   (req1_valid),
        .i_req1_a       (req1_a),
        .i_req1_b       (req1_b),
        .o_req1_ready_c (req1_ready),
        .o_resp0_valid  (resp0_valid),
        .o_resp1_valid  (resp1_valid),
        .o_resp_product (resp_product),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        int   port;
        if (rst_n) begin
            if (req0_ready || req1_ready)
                check("one_ready", 32'(req0_ready && req1_ready), 32'd0);
            if (resp0_valid || resp1_valid) begin
                port = (resp0_valid && !resp1_valid) ? 0 : (resp1_valid && !resp0_valid) ? 1 : 2;
                if (sb_q.size() == 0) begin
                    check("unexpected_resp", 32'(port), 32'd99);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_port", 32'(port), 32'(e.port));
                    check("resp_product", 32'(resp_product), 32'(e.prod));
                    check("resp_latency", 32'(cyc - e.cyc), 32'd9);
                end
            end
        end
    end

    // Present one request; call just after a rising edge. Returns just after the handshake edge.
    task automatic drive(input int p, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod, input bit push, input bit drop);
        bit   got = 1'b0;
        exp_t e;
        #1;
        if (p == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else        begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? req0_ready : req1_ready;
        end
        check("handshake_seen", 32'(got), 32'd1);
        if (got) begin
            hs_port.push_back(p);
            hs_cyc.push_back(cyc);
            if (push) begin
                e.port = p; e.prod = prod; e.cyc = cyc;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        if (drop) begin
            #1;
            if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(resp_product), 32'd0);
        check("rst_resp0", 32'(resp0_valid), 32'd0);
        check("rst_resp1", 32'(resp1_valid), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        do_reset();

        // Single requests, including operand extremes
        drive(0, 8'd13, 8'd11, 16'd143, 1, 1);
        drain();
        drive(1, 8'hFF, 8'hFF, 16'hFE01, 1, 1);
        drain();
        drive(0, 8'h00, 8'hA5, 16'h0000, 1, 1);
        drain();
        drive(1, 8'h01, 8'h80, 16'h0080, 1, 1);
        drain();

        // Tie from reset: requester 0 wins, requester 1 follows on the next IDLE cycle
        do_reset();
        hs_port.delete(); hs_cyc.delete();
        fork
            drive(0, 8'd3, 8'd4, 16'd12, 1, 1);
            drive(1, 8'd5, 8'd6, 16'd30, 1, 1);
        join
        drain();
        check("tie_first", 32'(hs_port[0]), 32'd0);
        check("tie_second", 32'(hs_port[1]), 32'd1);
        check("tie_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd10);

        // Continuous contention alternates grants
        hs_port.delete(); hs_cyc.delete();
        fork
            begin
                drive(0, 8'd2, 8'd50, 16'd100, 1, 0);
                drive(0, 8'd17, 8'd15, 16'd255, 1, 1);
            end
            begin
                drive(1, 8'd200, 8'd3, 16'd600, 1, 0);
                drive(1, 8'd128, 8'd2, 16'd256, 1, 1);
            end
        join
        drain();
        for (int i = 0; i < 4; i++) check("alt_port", 32'(hs_port[i]), 32'(i % 2));
        for (int i = 1; i < 4; i++) check("alt_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd10);

        // Late arrival during CALC waits without ready, operands kept
        hs_port.delete(); hs_cyc.delete();
        fork
            drive(0, 8'd2, 8'd3, 16'd6, 1, 1);
            begin
                repeat (3) @(posedge clk);
                #1;
                req1_a = 8'd9; req1_b = 8'd10; req1_valid = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("busy_ready1", 32'(req1_ready), 32'd0);
                    check("busy_high", 32'(busy), 32'd1);
                end
                @(posedge clk);
                drive(1, 8'd9, 8'd10, 16'd90, 1, 1);
            end
        join
        drain();
        check("late_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd10);

        // Reset mid-CALC discards the operation
        drive(0, 8'd100, 8'd100, 16'd0, 0, 1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(resp_product), 32'd0);
        check("midrst_resp0", 32'(resp0_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(posedge clk);
        check("midrst_product_hold", 32'(resp_product), 32'd0);
        drive(0, 8'd7, 8'd9, 16'd63, 1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
